// File: rtl/lsu_pkg.sv
// Shared constants and helpers for the LSU simulation-memory initiator.
// Size encodings, FSM state codes and store length masks.
package lsu_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned MASK_W = 8;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [MASK_W-1:0] MASK_B = 8'h01;
  localparam logic [MASK_W-1:0] MASK_H = 8'h03;
  localparam logic [MASK_W-1:0] MASK_W4 = 8'h0F;
  localparam logic [MASK_W-1:0] MASK_D = 8'hFF;

  function automatic logic [MASK_W-1:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return MASK_B;
      SIZE_H:  return MASK_H;
      SIZE_W:  return MASK_W4;
      default: return MASK_D;
    endcase
  endfunction

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'b000;
      SIZE_H:  return 3'b001;
      SIZE_W:  return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] byte_expand(input logic [MASK_W-1:0] m);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < int'(MASK_W); i++) r[i*8 +: 8] = {8{m[i]}};
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Selects the low 2^size bytes of read data and sign/zero extends to 64 bits.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [DATA_W-1:0] rd_data,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] ext_data
);

  always_comb begin
    ext_data = rd_data;
    case (size)
      SIZE_B:  ext_data = is_unsigned ? {56'b0, rd_data[7:0]}  : {{56{rd_data[7]}},  rd_data[7:0]};
      SIZE_H:  ext_data = is_unsigned ? {48'b0, rd_data[15:0]} : {{48{rd_data[15]}}, rd_data[15:0]};
      SIZE_W:  ext_data = is_unsigned ? {32'b0, rd_data[31:0]} : {{32{rd_data[31]}}, rd_data[31:0]};
      default: ext_data = rd_data;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator onto the single-cycle DPI memory port.
// Optional LSU_ALIGN_CHECK_EN: misaligned requests skip memory and respond with resp_err.
module lsu_mem_master
  import lsu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_we_en,
  output logic [ADDR_W-1:0] mem_we_addr,
  output logic [DATA_W-1:0] mem_we_data,
  output logic [MASK_W-1:0] mem_we_mask
);

  logic [1:0]        state, next_state;
  logic              wen_q, uns_q, mis_q, mis_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, load_data;
  logic [1:0]        size_q;
  logic              accept, rd_go, we_go;

  assign req_ready  = (state == ST_IDLE) | ((state == ST_RESP) & resp_ready);
  assign resp_valid = (state == ST_RESP);
  assign accept     = req_valid & req_ready;

`ifdef LSU_ALIGN_CHECK_EN
  assign mis_d = |(req_addr[2:0] & align_mask(req_size));
`else
  assign mis_d = 1'b0;
`endif

  // Strobes exist only in an ACCESS cycle of an aligned request, never under reset.
  assign rd_go = (state == ST_ACCESS) & ~mis_q & ~wen_q & ~reset;
  assign we_go = (state == ST_ACCESS) & ~mis_q &  wen_q & ~reset;

  assign mem_rd_en   = rd_go;
  assign mem_rd_addr = rd_go ? addr_q : '0;
  assign mem_we_en   = we_go;
  assign mem_we_addr = we_go ? addr_q : '0;
  assign mem_we_data = we_go ? (wdata_q & byte_expand(size_mask(size_q))) : '0;
  assign mem_we_mask = we_go ? size_mask(size_q) : '0;

  lsu_load_ext u_load_ext (
    .rd_data     (mem_rd_data),
    .size        (size_q),
    .is_unsigned (uns_q),
    .ext_data    (load_data)
  );

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (accept) next_state = ST_ACCESS;
      ST_ACCESS: next_state = ST_RESP;
      ST_RESP:   if (resp_ready) next_state = req_valid ? ST_ACCESS : ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      wen_q      <= 1'b0;
      uns_q      <= 1'b0;
      mis_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= next_state;
      if (accept) begin
        wen_q   <= req_wen;
        uns_q   <= req_unsigned;
        mis_q   <= mis_d;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
      if (state == ST_ACCESS) begin
        resp_rdata <= (wen_q | mis_q) ? '0 : load_data;
        resp_err   <= mis_q;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed cases plus randomized traffic against a byte-level model.
module tb_lsu_mem_master;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_rd_en, mem_we_en;
  logic [63:0] mem_rd_addr, mem_rd_data, mem_we_addr, mem_we_data;
  logic [7:0]  mem_we_mask;
  logic [63:0] mem_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Garbage outside a read strobe exposes any sampling outside ACCESS.
  assign mem_rd_data = mem_rd_en ? mem_data : 64'hDEAD_0BAD_DEAD_0BAD;

  always #5 clock = ~clock;

  lsu_mem_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_we_en(mem_we_en), .mem_we_addr(mem_we_addr),
    .mem_we_data(mem_we_data), .mem_we_mask(mem_we_mask)
  );

  typedef struct {
    logic        rdy;
    logic        rd_en;
    logic [63:0] rd_addr;
    logic        we_en;
    logic [63:0] we_addr;
    logic [63:0] we_data;
    logic [7:0]  we_mask;
    logic        rvalid;
    logic [63:0] rdata;
    logic        err;
    logic        post_strobe;
    logic        idle_valid;
  } obs_t;

  // Reference model: arithmetic on byte counts, independent of the RTL structure.
  function automatic logic [63:0] m_load(input logic [63:0] d, input logic [1:0] sz, input logic uns);
    int nb;
    logic [63:0] m, v;
    nb = 1 << sz;
    if (nb == 8) return d;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = d & m;
    if (!uns && d[8 * nb - 1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [7:0] m_mask(input logic [1:0] sz);
    logic [8:0] t;
    t = (9'd1 << (1 << sz)) - 9'd1;
    return t[7:0];
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] w, input logic [1:0] sz);
    if (sz == 2'd3) return w;
    return w & ((64'd1 << (8 << sz)) - 64'd1);
  endfunction

  function automatic logic m_mis(input logic [63:0] a, input logic [1:0] sz);
    return ALIGN_EN && ((a % (64'd1 << sz)) != 64'd0);
  endfunction

  // Runs one isolated transaction from IDLE with resp_ready high; starts and ends at a negedge.
  task automatic run_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [1:0] sz, input logic uns, input logic [63:0] mdata,
                         output obs_t o);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = sz; req_unsigned = uns; mem_data = mdata;
    #1 o.rdy = req_ready;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    req_addr  = ~addr;
    o.rd_en = mem_rd_en; o.rd_addr = mem_rd_addr; o.we_en = mem_we_en;
    o.we_addr = mem_we_addr; o.we_data = mem_we_data; o.we_mask = mem_we_mask;
    @(posedge clock); @(negedge clock);
    o.rvalid = resp_valid; o.rdata = resp_rdata; o.err = resp_err;
    o.post_strobe = mem_rd_en | mem_we_en;
    @(posedge clock); @(negedge clock);
    o.idle_valid = resp_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b1; mem_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
    n_checks++; if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp got %h/%b exp 0/0", resp_rdata, resp_err); end
    n_checks++;
    if ({mem_rd_en, mem_we_en, mem_rd_addr, mem_we_addr, mem_we_data, mem_we_mask} !== '0) begin
      n_fail++; $display("FAIL reset_mem_outputs got rd %b we %b raddr %h exp all 0", mem_rd_en, mem_we_en, mem_rd_addr);
    end
  endtask

  task automatic test_directed();
    obs_t o;
    run_txn(1'b0, 64'h8000_0000, 64'd0, 2'd3, 1'b0, 64'h1122334455667788, o);
    n_checks++; if (o.rdy !== 1'b1) begin n_fail++; $display("FAIL ld_d_ready got %b exp 1", o.rdy); end
    n_checks++; if (o.rd_en !== 1'b1 || o.rd_addr !== 64'h8000_0000) begin n_fail++; $display("FAIL ld_d_strobe got %b %h exp 1 80000000", o.rd_en, o.rd_addr); end
    n_checks++; if (o.rvalid !== 1'b1 || o.rdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL ld_d_rdata got %b %h exp 1 1122334455667788", o.rvalid, o.rdata); end
    n_checks++; if (o.post_strobe !== 1'b0) begin n_fail++; $display("FAIL ld_d_single_strobe got %b exp 0", o.post_strobe); end
    n_checks++; if (o.idle_valid !== 1'b0) begin n_fail++; $display("FAIL ld_d_valid_drop got %b exp 0", o.idle_valid); end

    run_txn(1'b0, 64'h8000_0008, 64'd0, 2'd0, 1'b0, 64'h1234567890ABCD80, o);
    n_checks++; if (o.rdata !== 64'hFFFF_FFFF_FFFF_FF80) begin n_fail++; $display("FAIL ld_b_signed got %h exp ffffffffffffff80", o.rdata); end
    run_txn(1'b0, 64'h8000_0008, 64'd0, 2'd0, 1'b1, 64'h1234567890ABCD80, o);
    n_checks++; if (o.rdata !== 64'h0000_0000_0000_0080) begin n_fail++; $display("FAIL ld_b_unsigned got %h exp 80", o.rdata); end

    run_txn(1'b1, 64'h8000_0010, 64'hDEADBEEFCAFEBABE, 2'd2, 1'b0, 64'h5555_5555_5555_5555, o);
    n_checks++; if (o.we_en !== 1'b1 || o.rd_en !== 1'b0 || o.we_addr !== 64'h8000_0010) begin n_fail++; $display("FAIL st_w_strobe got we %b rd %b %h exp 1 0 80000010", o.we_en, o.rd_en, o.we_addr); end
    n_checks++; if (o.we_mask !== 8'h0F || o.we_data !== 64'h0000_0000_CAFE_BABE) begin n_fail++; $display("FAIL st_w_mask_data got %h %h exp 0f 00000000cafebabe", o.we_mask, o.we_data); end
    n_checks++; if (o.rdata !== 64'd0 || o.post_strobe !== 1'b0) begin n_fail++; $display("FAIL st_w_resp got %h %b exp 0 0", o.rdata, o.post_strobe); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_txn(1'b0, 64'h8000_0001, 64'd0, 2'd1, 1'b0, 64'h0000_0000_0000_8001, o);
    n_checks++; if (o.rd_en !== !ALIGN_EN) begin n_fail++; $display("FAIL mis_strobe got %b exp %b", o.rd_en, !ALIGN_EN); end
    n_checks++; if (o.err !== ALIGN_EN) begin n_fail++; $display("FAIL mis_err got %b exp %b", o.err, ALIGN_EN); end
    n_checks++;
    if (o.rdata !== (ALIGN_EN ? 64'd0 : 64'hFFFF_FFFF_FFFF_8001)) begin
      n_fail++; $display("FAIL mis_rdata got %h exp %h", o.rdata, ALIGN_EN ? 64'd0 : 64'hFFFF_FFFF_FFFF_8001);
    end
    n_checks++; if (!ALIGN_EN && o.rd_addr !== 64'h8000_0001) begin n_fail++; $display("FAIL mis_addr got %h exp 80000001", o.rd_addr); end
  endtask

  task automatic test_random();
    obs_t o;
    logic wen, uns, mis;
    logic [1:0] sz;
    logic [63:0] addr, wdata, md;
    for (int i = 0; i < 40; i++) begin
      wen = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1)); sz = 2'($urandom_range(0, 3));
      addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; md = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
      mis = m_mis(addr, sz);
      run_txn(wen, addr, wdata, sz, uns, md, o);
      n_checks++; if (o.rd_en !== (!wen && !mis) || o.we_en !== (wen && !mis)) begin n_fail++; $display("FAIL rnd%0d_strobes got rd %b we %b exp rd %b we %b", i, o.rd_en, o.we_en, !wen && !mis, wen && !mis); end
      n_checks++; if (o.rd_addr !== ((!wen && !mis) ? addr : 64'd0)) begin n_fail++; $display("FAIL rnd%0d_rd_addr got %h exp %h", i, o.rd_addr, (!wen && !mis) ? addr : 64'd0); end
      n_checks++; if (o.we_addr !== ((wen && !mis) ? addr : 64'd0)) begin n_fail++; $display("FAIL rnd%0d_we_addr got %h exp %h", i, o.we_addr, (wen && !mis) ? addr : 64'd0); end
      n_checks++; if (o.we_mask !== ((wen && !mis) ? m_mask(sz) : 8'd0)) begin n_fail++; $display("FAIL rnd%0d_we_mask got %h exp %h", i, o.we_mask, (wen && !mis) ? m_mask(sz) : 8'd0); end
      n_checks++; if (o.we_data !== ((wen && !mis) ? m_wdata(wdata, sz) : 64'd0)) begin n_fail++; $display("FAIL rnd%0d_we_data got %h exp %h", i, o.we_data, (wen && !mis) ? m_wdata(wdata, sz) : 64'd0); end
      n_checks++; if (o.rdata !== ((wen || mis) ? 64'd0 : m_load(md, sz, uns))) begin n_fail++; $display("FAIL rnd%0d_rdata got %h exp %h", i, o.rdata, (wen || mis) ? 64'd0 : m_load(md, sz, uns)); end
      n_checks++; if (o.rvalid !== 1'b1 || o.err !== mis) begin n_fail++; $display("FAIL rnd%0d_resp got valid %b err %b exp 1 %b", i, o.rvalid, o.err, mis); end
      n_checks++; if (o.post_strobe !== 1'b0 || o.idle_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_after got strobe %b valid %b exp 0 0", i, o.post_strobe, o.idle_valid); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] md;
    md = {$urandom, $urandom};
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0100; req_wdata = 64'h0123_4567_89AB_CDEF;
    req_size = 2'd3; req_unsigned = 1'b0; mem_data = md;
    @(posedge clock); @(negedge clock);
    n_checks++; if (mem_we_en !== 1'b1 || mem_we_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL b2b_store got %b %h exp 1 0123456789abcdef", mem_we_en, mem_we_data); end
    req_wen = 1'b0; req_addr = 64'h8000_0200; req_size = 2'd2; req_unsigned = 1'b1;
    @(posedge clock); @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_resp_ready got valid %b ready %b exp 1 1", resp_valid, req_ready); end
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    n_checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 64'h8000_0200 || resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_second_access got rd %b %h valid %b exp 1 80000200 0", mem_rd_en, mem_rd_addr, resp_valid); end
    @(posedge clock); @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== m_load(md, 2'd2, 1'b1)) begin n_fail++; $display("FAIL b2b_second_rdata got %b %h exp 1 %h", resp_valid, resp_rdata, m_load(md, 2'd2, 1'b1)); end
    @(posedge clock); @(negedge clock);
  endtask

  task automatic test_backpressure();
    logic [63:0] d1, d2;
    d1 = {$urandom, $urandom}; d2 = {$urandom, $urandom};
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0300; req_size = 2'd3; req_unsigned = 1'b0;
    mem_data = d1; resp_ready = 1'b0;
    @(posedge clock); @(negedge clock);
    req_addr = 64'h8000_0400;
    @(posedge clock); @(negedge clock);
    mem_data = d2;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== d1 || resp_err !== 1'b0) begin n_fail++; $display("FAIL bp%0d_hold got %b %h %b exp 1 %h 0", i, resp_valid, resp_rdata, resp_err, d1); end
      n_checks++; if (req_ready !== 1'b0 || mem_rd_en !== 1'b0 || mem_we_en !== 1'b0) begin n_fail++; $display("FAIL bp%0d_stall got ready %b rd %b we %b exp 0 0 0", i, req_ready, mem_rd_en, mem_we_en); end
      @(posedge clock); @(negedge clock);
    end
    resp_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1", req_ready); end
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    n_checks++; if (mem_rd_en !== 1'b1 || mem_rd_addr !== 64'h8000_0400) begin n_fail++; $display("FAIL bp_next_access got %b %h exp 1 80000400", mem_rd_en, mem_rd_addr); end
    @(posedge clock); @(negedge clock);
    n_checks++; if (resp_valid !== 1'b1 || resp_rdata !== d2) begin n_fail++; $display("FAIL bp_next_rdata got %b %h exp 1 %h", resp_valid, resp_rdata, d2); end
    @(posedge clock); @(negedge clock);
  endtask

  task automatic test_reset_mid();
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0500; req_wdata = 64'hAAAA_BBBB_CCCC_DDDD;
    req_size = 2'd3; req_unsigned = 1'b0;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0;
    n_checks++; if (mem_we_en !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_we got %b exp 1", mem_we_en); end
    reset = 1'b1;
    #1;
    n_checks++; if (mem_we_en !== 1'b0 || mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_we_forced got we %b rd %b exp 0 0", mem_we_en, mem_rd_en); end
    @(posedge clock); @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_we_en !== 1'b0) begin n_fail++; $display("FAIL rstmid%0d_idle got valid %b ready %b we %b exp 0 1 0", i, resp_valid, req_ready, mem_we_en); end
      @(posedge clock); @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_random();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
